// File: rtl/bf_pkg.sv
// Shared types and helpers for the boolean-function equivalence sweeper.
package bf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Counters must hold 2^n, so they need one bit more than the vector.
  function automatic int cnt_w(input int n);
    return n + 1;
  endfunction

endpackage

// File: rtl/bf_equiv_sweeper_if.sv
// Control/result bundle between the sweeper and its switch/display surroundings.
interface bf_equiv_sweeper_if #(
  parameter int N_IN = 3
) ();
  import bf_pkg::*;

  logic                   start;
  logic                   mode;
  logic [N_IN-1:0]        vec_in;
  logic                   busy;
  logic                   res_valid;
  logic [N_IN-1:0]        res_vec;
  logic                   d_out;
  logic                   e_out;
  logic                   done;
  logic [cnt_w(N_IN)-1:0] d_ones_cnt;
  logic [cnt_w(N_IN)-1:0] mismatch_cnt;
  logic                   err;
  logic [N_IN-1:0]        first_fail_vec;

  modport master (
    output start, mode, vec_in,
    input  busy, res_valid, res_vec, d_out, e_out, done,
    input  d_ones_cnt, mismatch_cnt, err, first_fail_vec
  );

  modport slave (
    input  start, mode, vec_in,
    output busy, res_valid, res_vec, d_out, e_out, done,
    output d_ones_cnt, mismatch_cnt, err, first_fail_vec
  );

endinterface

// File: rtl/bf_eval.sv
// Combinational evaluation of the SOP form D and the NAND-of-OR form E.
// FAULT_INJ_EN adds fault_inj, which inverts E for the all-ones vector.
module bf_eval #(
  parameter int N_IN = 3
) (
  input  logic [N_IN-1:0] vec,
`ifdef FAULT_INJ_EN
  input  logic            fault_inj,
`endif
  output logic            d,
  output logic            e
);

  logic e_raw_s;

  assign d       = (&(~vec[N_IN-2:0])) | ~vec[N_IN-1];
  assign e_raw_s = ~((|vec[N_IN-2:0]) & vec[N_IN-1]);

`ifdef FAULT_INJ_EN
  assign e = e_raw_s ^ (fault_inj & (&vec));
`else
  assign e = e_raw_s;
`endif

endmodule

// File: rtl/bf_equiv_sweeper.sv
// Sweeps (or singly evaluates) input vectors, comparing D and E forms.
// FAULT_INJ_EN adds the fault_inj port used to force a D/E mismatch.
module bf_equiv_sweeper
  import bf_pkg::*;
#(
  parameter int N_IN = 3
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef FAULT_INJ_EN
  input  logic               fault_inj,
`endif
  bf_equiv_sweeper_if.slave  bus
);

  localparam int              CW      = cnt_w(N_IN);
  localparam logic [N_IN-1:0] VEC_ONE = {{(N_IN-1){1'b0}}, 1'b1};
  localparam logic [N_IN-1:0] VEC_MAX = {N_IN{1'b1}};
  localparam logic [CW-1:0]   CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]   CNT_MAX = {CW{1'b1}};

  state_t          state_r;
  state_t          state_nxt_s;
  logic            mode_r;
  logic [N_IN-1:0] issue_r;

  logic            busy_s;
  logic            done_s;
  logic            accept_s;
  logic            run_s;

  logic            d_eval_s;
  logic            e_eval_s;
  logic            mism_s;

  logic            res_valid_r;
  logic [N_IN-1:0] res_vec_r;
  logic            d_r;
  logic            e_r;
  logic [CW-1:0]   d_ones_r;
  logic [CW-1:0]   mismatch_r;
  logic            err_r;
  logic [N_IN-1:0] first_fail_r;

  bf_eval #(.N_IN(N_IN)) u_eval (
    .vec       (issue_r),
`ifdef FAULT_INJ_EN
    .fault_inj (fault_inj),
`endif
    .d         (d_eval_s),
    .e         (e_eval_s)
  );

  assign mism_s = d_eval_s ^ e_eval_s;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; mode 1 always leaves RUN after its single issue
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (mode_r || (issue_r == VEC_MAX)) begin
          state_nxt_s = FLUSH;
        end else begin
          state_nxt_s = RUN;
        end
      end
      FLUSH:   state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Control decode from the registered state
  always_comb begin
    busy_s   = 1'b0;
    done_s   = 1'b0;
    accept_s = 1'b0;
    run_s    = 1'b0;
    case (state_r)
      IDLE:  accept_s = bus.start;
      RUN: begin
        busy_s = 1'b1;
        run_s  = 1'b1;
      end
      FLUSH: begin
        busy_s = 1'b1;
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  // Issue register and captured mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_r <= '0;
      mode_r  <= 1'b0;
    end else if (accept_s) begin
      issue_r <= bus.mode ? bus.vec_in : '0;
      mode_r  <= bus.mode;
    end else if (run_s && !mode_r) begin
      issue_r <= issue_r + VEC_ONE;
    end else begin
      issue_r <= issue_r;
    end
  end

  // Result pipeline stage; forced to zero outside RUN issue cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_r <= 1'b0;
      res_vec_r   <= '0;
      d_r         <= 1'b0;
      e_r         <= 1'b0;
    end else begin
      res_valid_r <= run_s;
      res_vec_r   <= run_s ? issue_r : '0;
      d_r         <= run_s & d_eval_s;
      e_r         <= run_s & e_eval_s;
    end
  end

  // Saturating counters and sticky first-failure capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_ones_r     <= '0;
      mismatch_r   <= '0;
      err_r        <= 1'b0;
      first_fail_r <= '0;
    end else if (accept_s) begin
      d_ones_r     <= '0;
      mismatch_r   <= '0;
      err_r        <= 1'b0;
      first_fail_r <= '0;
    end else if (run_s) begin
      if (d_eval_s && (d_ones_r != CNT_MAX)) begin
        d_ones_r <= d_ones_r + CNT_ONE;
      end
      if (mism_s && (mismatch_r != CNT_MAX)) begin
        mismatch_r <= mismatch_r + CNT_ONE;
      end
      if (mism_s) begin
        err_r <= 1'b1;
      end
      if (mism_s && !err_r) begin
        first_fail_r <= issue_r;
      end
    end
  end

  assign bus.busy           = busy_s;
  assign bus.done           = done_s;
  assign bus.res_valid      = res_valid_r;
  assign bus.res_vec        = res_vec_r;
  assign bus.d_out          = d_r;
  assign bus.e_out          = e_r;
  assign bus.d_ones_cnt     = d_ones_r;
  assign bus.mismatch_cnt   = mismatch_r;
  assign bus.err            = err_r;
  assign bus.first_fail_vec = first_fail_r;

endmodule

// File: doc/bf_equiv_sweeper.md
Name: bf_equiv_sweeper

Overview:
Parametrised, sequential successor to the 3-input boolean-function lab block. Evaluates the generalised function in two algebraically equivalent forms, SOP-style D and NAND-of-OR-style E, over an N_IN-bit input vector. Either sweeps every input combination or evaluates one external vector. Counts D ones and D/E mismatches, and reports the first failing vector. Sits between board switches/start button and LED/7-seg display logic.

Parameters:
N_IN, 3, input vector width; legal range 2..12; vec[N_IN-1] is the "C" input, vec[N_IN-2:0] are the "A,B,..." inputs.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a run; sampled only in IDLE
mode  input  1  0 = exhaustive sweep, 1 = single vector; sampled with start
vec_in  input  N_IN  vector for mode 1; captured when start is accepted
busy  output  1  high in RUN and FLUSH
res_valid  output  1  d_out/e_out/res_vec valid this cycle
res_vec  output  N_IN  vector that produced d_out/e_out
d_out  output  1  D = (&~vec[N_IN-2:0]) | ~vec[N_IN-1]
e_out  output  1  E = ~((|vec[N_IN-2:0]) & vec[N_IN-1])
done  output  1  one-cycle pulse with the final result of a run
d_ones_cnt  output  N_IN+1  number of evaluated vectors with D=1
mismatch_cnt  output  N_IN+1  number of evaluated vectors with D != E
err  output  1  sticky: at least one mismatch this run
first_fail_vec  output  N_IN  first vector with D != E; 0 if none

Behaviour:
- Reset (rst_n low, asynchronous): state goes to IDLE immediately. All outputs and internal registers are 0. A reset mid-run aborts the run; no done pulse.
- States: IDLE, RUN, FLUSH.
- IDLE:
  - start=1 is accepted.
  - d_ones_cnt, mismatch_cnt, err and first_fail_vec clear on the accept edge.
  - Issue register loads 0 (mode 0) or vec_in (mode 1).
  - Next state is RUN.
- RUN:
  - One vector is issued per cycle. Mode 0 increments the issue register by 1 each cycle.
  - Go to FLUSH after issuing 2^N_IN-1 (mode 0) or after the single issue (mode 1).
- FLUSH: lasts exactly one cycle, then IDLE.
- start is ignored while busy. mode and vec_in changes while busy have no effect.
- Latency: a vector issued in cycle t appears on res_vec/d_out/e_out with res_valid=1 in cycle t+1.
- Counters update on the same edge as d_out, so their values in cycle t+1 include vector t.
- done=1 in the FLUSH cycle, coincident with the last res_valid.
  - Mode 0: done occurs 2^N_IN+1 cycles after the start-accept edge.
  - Mode 1: done occurs 2 cycles after the start-accept edge.
- Counters saturate at all-ones (unreachable for legal N_IN; required anyway).
- first_fail_vec loads only when err is 0 and a mismatch occurs.
- After done, the counters, err and first_fail_vec hold until the next accepted start. res_valid and d_out/e_out/res_vec return to 0 in IDLE.
- Issue-register wrap from all-ones to 0 is never observed: the FSM leaves RUN first.

Optional Feature:
FAULT_INJ_EN:
- Defined: adds input port fault_inj (1 bit). While fault_inj=1, the evaluated E is inverted for the all-ones vector only. This exercises the mismatch path.
- Undefined: no port, and E is always the correct function.

Decomposition:
- Package bf_pkg: state enum (IDLE, RUN, FLUSH) and a width helper function cnt_w(n) = n+1.
- One natural combinational sub-module, bf_eval: parameter N_IN, input vec, outputs d and e. It is instantiated once and holds the fault-inversion mux under FAULT_INJ_EN.
- FSM, issue register, output registers and counters stay in bf_equiv_sweeper.

Test Plan:
- N_IN=3, mode 0, start pulse -> res_vec 0..7 on consecutive cycles; d_out=1 for 0-4 and 0 for 5-7; done 9 cycles after accept; d_ones_cnt=5, mismatch_cnt=0, err=0.
- N_IN=4, mode 0 -> done 17 cycles after accept; d_ones_cnt=9, mismatch_cnt=0.
- N_IN=3, mode 1, vec_in=3'b110 -> res_valid and done 2 cycles after accept; d_out=0, e_out=0, d_ones_cnt=0.
- Mid-sweep: start re-pulsed -> ignored. rst_n low at res_vec=4 -> all outputs 0 immediately; no done. New start after release -> full 8-vector sweep.
- FAULT_INJ_EN, N_IN=3, fault_inj=1, mode 0 -> mismatch_cnt=1, err=1, first_fail_vec=3'b111; err stays 1 after done until the next start.
- Back-to-back: start held high continuously -> second run accepted the cycle after FLUSH; counters cleared on re-accept.
